// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: access-size encodings and helpers shared by the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_WX = 2'b11
    } size_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // Encoding 11 behaves as a word access everywhere.
    function automatic size_e norm_size(input logic [1:0] sz);
        if (sz == 2'b11) begin
            return SZ_W;
        end
        return size_e'(sz);
    endfunction

    function automatic size_e f3_to_size(input logic [2:0] f3);
        return norm_size(f3[1:0]);
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        logic r;
        r = 1'b0;
        case (norm_size(sz))
            SZ_H:    r = off[0];
            SZ_W:    r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store strobe/lane replication and load extract with zero-extend.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wlane,
    output logic [31:0] rext
);

    size_e sz;

    assign sz = norm_size(size);

    // Half ignores off[0] and word ignores off, so misaligned offsets truncate.
    always_comb begin
        wstrb = 4'b1111;
        wlane = wdata;
        rext  = rdata;
        unique case (1'b1)
            sz == SZ_B: begin
                wstrb = 4'b0001 << off;
                wlane = {4{wdata[7:0]}};
                rext  = {24'h0, rdata[{off, 3'b000} +: 8]};
            end
            sz == SZ_H: begin
                wstrb = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                rext  = {16'h0, rdata[{off[1], 4'b0000} +: 16]};
            end
            default: begin
                wstrb = 4'b1111;
                wlane = wdata;
                rext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between fetch and load/store ports.
// Define MISALIGN_TRAP_EN to flag and suppress misaligned data accesses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [3:0]    m_wstrb,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          force_i;
    logic          mis;
    logic          wr_ok;
    logic [3:0]    strb;
    logic [31:0]   wlane;
    logic [31:0]   rext;
    rsp_t          d_rsp;
    logic          unused_ok;

    assign force_i = (STARVE_LIMIT != 0) && (starve_cnt == LIM);
    assign d_gnt   = rst_n && d_req && !(force_i && i_req);
    assign i_gnt   = rst_n && i_req && !d_gnt;

`ifdef MISALIGN_TRAP_EN
    assign mis = is_misaligned(d_size, d_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    mem_lane_align u_align (
        .size  (d_size),
        .off   (d_addr[1:0]),
        .wdata (d_wdata),
        .rdata (m_rdata),
        .wstrb (strb),
        .wlane (wlane),
        .rext  (rext)
    );

    // Idle cycles present the fetch address as a harmless read.
    assign wr_ok   = d_gnt && d_we && !mis;
    assign m_addr  = d_gnt ? {d_addr[AW-1:2], 2'b00}
                           : {i_addr[AW-1:2], 2'b00};
    assign m_we    = wr_ok;
    assign m_wstrb = wr_ok ? strb : 4'b0000;
    assign m_wdata = wlane;

    assign d_rvalid  = d_rsp.valid;
    assign d_err     = d_rsp.err;
    assign d_rdata   = d_rsp.data;
    assign unused_ok = ^i_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= 32'h0;
            d_rsp      <= '0;
        end else begin
            if (i_req && !i_gnt) begin
                if (starve_cnt != LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
            i_rvalid <= i_gnt;
            if (i_gnt) begin
                i_rdata <= m_rdata;
            end
            d_rsp.valid <= d_gnt;
            d_rsp.err   <= d_gnt && mis;
            if (d_gnt) begin
                d_rsp.data <= (d_we || mis) ? 32'h0 : rext;
            end
        end
    end

endmodule
